// File: rtl/bank_txn_dispatcher.sv
// rtl/bank_txn_dispatcher.sv - single-entry request hold with per-bank dispatch and read tag/write credit tracking
module bank_txn_dispatcher #(
   parameter int DATA_W     = 16,
   parameter int NUM_BANKS  = 16,
   parameter int ADDR_W     = 24,
   parameter int RD_ENTRIES = 32,
   parameter int WR_MAX     = 32,
   localparam int BANK_W    = $clog2(NUM_BANKS),
   localparam int IDX_W     = $clog2(RD_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_type,
   input  logic [ADDR_W-1:0]    in_addr,
   output logic                 in_busy,
   output logic                 out_type,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [IDX_W-1:0]     out_index,
   output logic [NUM_BANKS-1:0] bank_out_valid,
   input  logic [NUM_BANKS-1:0] fifo_grant,
   input  logic                 done_valid,
   input  logic                 done_type,
   input  logic [IDX_W-1:0]     done_index,
   input  logic [DATA_W-1:0]    done_data,
   output logic                 read_done,
   output logic                 write_done,
   output logic [DATA_W-1:0]    data_out,
   output logic [IDX_W:0]       rd_outstanding,
   output logic [7:0]           wr_outstanding,
   output logic                 tag_err
);

   logic                  hold_valid;
   logic [BANK_W-1:0]     hold_bank;
   logic                  transfer;
   logic                  accept;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  rd_cpl;
   logic                  wr_cpl;
   logic                  rd_cpl_ok;
   logic                  wr_cpl_ok;
   logic [RD_ENTRIES-1:0] free_map;
   logic [RD_ENTRIES-1:0] free_nxt;
   logic [IDX_W-1:0]      alloc_idx;

   assign hold_bank      = out_addr[BANK_W-1:0];
   assign transfer       = hold_valid & fifo_grant[hold_bank];
   assign bank_out_valid = hold_valid ? (NUM_BANKS'(1) << hold_bank) : '0;

   assign in_busy = (hold_valid & ~transfer)
                  | (rd_outstanding == (IDX_W+1)'(RD_ENTRIES))
                  | (wr_outstanding == 8'(WR_MAX));

   assign accept    = in_valid & ~in_busy;
   assign rd_acc    = accept & ~in_type;
   assign wr_acc    = accept & in_type;
   assign rd_cpl    = done_valid & ~done_type;
   assign wr_cpl    = done_valid & done_type;
   // A completion only counts if it refers to something actually outstanding
   assign rd_cpl_ok = rd_cpl & ~free_map[done_index];
   assign wr_cpl_ok = wr_cpl & (wr_outstanding != 8'd0);

   always_comb begin
      alloc_idx = '0;
      for (int i = RD_ENTRIES - 1; i >= 0; i--) begin
         if (free_map[i]) alloc_idx = IDX_W'(i);
      end
   end

   // Allocation is applied after the free so a same-cycle alloc/free of one tag leaves it used
   always_comb begin
      free_nxt = free_map;
      if (rd_cpl_ok) free_nxt[done_index] = 1'b1;
      if (rd_acc)    free_nxt[alloc_idx]  = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         out_type   <= 1'b0;
         out_addr   <= '0;
         out_index  <= '0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         out_type   <= in_type;
         out_addr   <= in_addr;
         out_index  <= in_type ? '0 : alloc_idx;
      end else if (transfer) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_map       <= '1;
         rd_outstanding <= '0;
         wr_outstanding <= '0;
         tag_err        <= 1'b0;
      end else begin
         free_map <= free_nxt;
         case ({rd_acc, rd_cpl_ok})
            2'b10:   rd_outstanding <= rd_outstanding + (IDX_W+1)'(1);
            2'b01:   rd_outstanding <= rd_outstanding - (IDX_W+1)'(1);
            default: rd_outstanding <= rd_outstanding;
         endcase
         case ({wr_acc, wr_cpl_ok})
            2'b10:   wr_outstanding <= wr_outstanding + 8'd1;
            2'b01:   wr_outstanding <= wr_outstanding - 8'd1;
            default: wr_outstanding <= wr_outstanding;
         endcase
         if ((rd_cpl & ~rd_cpl_ok) | (wr_cpl & ~wr_cpl_ok)) tag_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_done  <= 1'b0;
         write_done <= 1'b0;
         data_out   <= '0;
      end else begin
         read_done  <= rd_cpl;
         write_done <= wr_cpl;
         if (rd_cpl) data_out <= done_data;
      end
   end

endmodule

// File: tb/tb_bank_txn_dispatcher.sv
// tb/tb_bank_txn_dispatcher.sv - scoreboard bench for bank_txn_dispatcher
module tb_bank_txn_dispatcher;

   typedef struct packed {
      logic        t;
      logic [23:0] a;
      logic [4:0]  i;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_type = 1'b0;
   logic [23:0] in_addr = '0;
   logic        in_busy;
   logic        out_type;
   logic [23:0] out_addr;
   logic [4:0]  out_index;
   logic [15:0] bank_out_valid;
   logic [15:0] fifo_grant = '1;
   logic        done_valid = 1'b0;
   logic        done_type = 1'b0;
   logic [4:0]  done_index = '0;
   logic [15:0] done_data = '0;
   logic        read_done;
   logic        write_done;
   logic [15:0] data_out;
   logic [5:0]  rd_outstanding;
   logic [7:0]  wr_outstanding;
   logic        tag_err;

   int checks = 0;
   int errors = 0;
   req_t        exp_q[$];
   logic [15:0] done_q[$];
   logic [31:0] m_free = '1;

   bank_txn_dispatcher dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_type(in_type), .in_addr(in_addr),
      .in_busy(in_busy), .out_type(out_type), .out_addr(out_addr), .out_index(out_index),
      .bank_out_valid(bank_out_valid), .fifo_grant(fifo_grant), .done_valid(done_valid),
      .done_type(done_type), .done_index(done_index), .done_data(done_data),
      .read_done(read_done), .write_done(write_done), .data_out(data_out),
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   // Transfer and read-return scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (|(bank_out_valid & fifo_grant)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL xfer_unexpected got %h", {out_type, out_addr, out_index});
            end else begin
               req_t e;
               e = exp_q.pop_front();
               if ({out_type, out_addr, out_index} !== e || bank_out_valid !== (16'h1 << e.a[3:0])) begin
                  errors++;
                  $display("FAIL xfer got %h/%h exp %h/%h", {out_type, out_addr, out_index},
                           bank_out_valid, e, 16'h1 << e.a[3:0]);
               end
            end
         end
         if (read_done) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL rdone_unexpected got %h", data_out);
            end else begin
               logic [15:0] d;
               d = done_q.pop_front();
               if (data_out !== d) begin
                  errors++;
                  $display("FAIL rdone_data got %h exp %h", data_out, d);
               end
            end
         end
      end
   end

   function automatic logic [4:0] lowest_free(input logic [31:0] f);
      lowest_free = '0;
      for (int i = 31; i >= 0; i--) if (f[i]) lowest_free = 5'(i);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic t, input logic [23:0] a);
      in_valid = 1'b1;
      in_type  = t;
      in_addr  = a;
   endtask

   task automatic expect_accept(input logic t, input logic [23:0] a);
      req_t e;
      e.t = t;
      e.a = a;
      e.i = '0;
      if (!t) begin
         e.i = lowest_free(m_free);
         m_free[e.i] = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   task automatic set_done(input logic t, input logic [4:0] idx, input logic [15:0] d, input logic legal);
      done_valid = 1'b1;
      done_type  = t;
      done_index = idx;
      done_data  = d;
      if (!t) done_q.push_back(d);
      if (!t && legal) m_free[idx] = 1'b1;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      done_valid = 1'b0;
      exp_q.delete();
      done_q.delete();
      m_free = '1;
      #7;
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bank_out_valid, out_type, out_addr, out_index, read_done, write_done, data_out,
           rd_outstanding, wr_outstanding, tag_err, in_busy} !== '0) begin
         errors++;
         $display("FAIL reset_state got bov=%h busy=%b rd=%0d wr=%0d", bank_out_valid, in_busy,
                  rd_outstanding, wr_outstanding);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_basic_read();
      apply_reset();
      fifo_grant = '1;
      set_req(1'b0, 24'h000005);
      expect_accept(1'b0, 24'h000005);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", in_busy); end
      cycle();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bank_out_valid !== 16'h0020 || out_index !== 5'd0 || rd_outstanding !== 6'd1) begin
         errors++;
         $display("FAIL basic_read got bov=%h idx=%0d rd=%0d exp 0020/0/1", bank_out_valid, out_index, rd_outstanding);
      end
      cycle();
   endtask

   task automatic test_hold_stall();
      apply_reset();
      fifo_grant = 16'hFFF7;
      set_req(1'b1, 24'h000103);
      expect_accept(1'b1, 24'h000103);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b0) begin errors++; $display("FAIL stall_first_busy got %b exp 0", in_busy); end
      cycle();
      set_req(1'b0, 24'h000011);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (in_busy !== 1'b1 || bank_out_valid !== 16'h0008) begin
            errors++;
            $display("FAIL stall_held got busy=%b bov=%h exp 1/0008", in_busy, bank_out_valid);
         end
         cycle();
      end
      fifo_grant = '1;
      expect_accept(1'b0, 24'h000011);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy got %b exp 0", in_busy); end
      cycle();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_outstanding !== 8'd1 || rd_outstanding !== 6'd1) begin
         errors++;
         $display("FAIL stall_counts got wr=%0d rd=%0d exp 1/1", wr_outstanding, rd_outstanding);
      end
      cycle();
   endtask

   task automatic test_tag_exhaust();
      apply_reset();
      fifo_grant = '1;
      for (int i = 0; i < 32; i++) begin
         set_req(1'b0, 24'(i));
         expect_accept(1'b0, 24'(i));
         @(negedge clk);
         checks++;
         if (in_busy !== 1'b0) begin errors++; $display("FAIL exhaust_busy_%0d got %b exp 0", i, in_busy); end
         cycle();
      end
      set_req(1'b0, 24'h000040);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b1 || rd_outstanding !== 6'd32) begin
         errors++;
         $display("FAIL exhaust_full got busy=%b rd=%0d exp 1/32", in_busy, rd_outstanding);
      end
      cycle();
      set_done(1'b0, 5'd7, 16'hBEEF, 1'b1);
      cycle();
      done_valid = 1'b0;
      expect_accept(1'b0, 24'h000040);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b0 || rd_outstanding !== 6'd31) begin
         errors++;
         $display("FAIL exhaust_free got busy=%b rd=%0d exp 0/31", in_busy, rd_outstanding);
      end
      cycle();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_outstanding !== 6'd32 || out_index !== 5'd7) begin
         errors++;
         $display("FAIL exhaust_realloc got rd=%0d idx=%0d exp 32/7", rd_outstanding, out_index);
      end
      cycle();
   endtask

   task automatic test_same_cycle();
      apply_reset();
      fifo_grant = '1;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b0, 24'h000020 + 24'(i));
         expect_accept(1'b0, 24'h000020 + 24'(i));
         cycle();
      end
      set_req(1'b0, 24'h000007);
      expect_accept(1'b0, 24'h000007);
      set_done(1'b0, 5'd2, 16'h1234, 1'b1);
      cycle();
      in_valid   = 1'b0;
      done_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_outstanding !== 6'd3 || read_done !== 1'b1 || data_out !== 16'h1234) begin
         errors++;
         $display("FAIL same_cycle got rd=%0d rdone=%b data=%h exp 3/1/1234", rd_outstanding, read_done, data_out);
      end
      cycle();
      @(negedge clk);
      checks++;
      if (read_done !== 1'b0 || data_out !== 16'h1234) begin
         errors++;
         $display("FAIL same_cycle_pulse got rdone=%b data=%h exp 0/1234", read_done, data_out);
      end
      cycle();
   endtask

   task automatic test_write_credits();
      apply_reset();
      fifo_grant = '1;
      for (int i = 0; i < 32; i++) begin
         set_req(1'b1, 24'h000300 + 24'(i));
         expect_accept(1'b1, 24'h000300 + 24'(i));
         cycle();
      end
      set_req(1'b0, 24'h000001);
      @(negedge clk);
      checks++;
      if (in_busy !== 1'b1 || wr_outstanding !== 8'd32 || rd_outstanding !== 6'd0) begin
         errors++;
         $display("FAIL wr_full got busy=%b wr=%0d rd=%0d exp 1/32/0", in_busy, wr_outstanding, rd_outstanding);
      end
      cycle();
      in_valid = 1'b0;
      set_done(1'b1, 5'd0, 16'h0, 1'b1);
      cycle();
      done_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (write_done !== 1'b1 || read_done !== 1'b0 || wr_outstanding !== 8'd31 || in_busy !== 1'b0) begin
         errors++;
         $display("FAIL wr_done got wdone=%b rdone=%b wr=%0d busy=%b exp 1/0/31/0", write_done, read_done,
                  wr_outstanding, in_busy);
      end
      cycle();
   endtask

   task automatic test_tag_err();
      apply_reset();
      set_done(1'b0, 5'd9, 16'h5555, 1'b0);
      cycle();
      done_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (read_done !== 1'b1 || tag_err !== 1'b1 || rd_outstanding !== 6'd0) begin
         errors++;
         $display("FAIL tag_err_rd got rdone=%b err=%b rd=%0d exp 1/1/0", read_done, tag_err, rd_outstanding);
      end
      cycle();
      set_done(1'b1, 5'd0, 16'h0, 1'b0);
      cycle();
      done_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (write_done !== 1'b1 || wr_outstanding !== 8'd0 || tag_err !== 1'b1) begin
         errors++;
         $display("FAIL tag_err_wr got wdone=%b wr=%0d err=%b exp 1/0/1", write_done, wr_outstanding, tag_err);
      end
      repeat (3) cycle();
      @(negedge clk);
      checks++;
      if (tag_err !== 1'b1 || write_done !== 1'b0) begin
         errors++;
         $display("FAIL tag_err_sticky got err=%b wdone=%b exp 1/0", tag_err, write_done);
      end
      cycle();
      apply_reset();
      @(negedge clk);
      checks++;
      if (tag_err !== 1'b0) begin errors++; $display("FAIL tag_err_clear got %b exp 0", tag_err); end
      cycle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      fifo_grant = '1;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b0, 24'h000100 + 24'(i));
         expect_accept(1'b0, 24'h000100 + 24'(i));
         cycle();
      end
      set_req(1'b0, 24'h000104);
      expect_accept(1'b0, 24'h000104);
      cycle();
      fifo_grant = '0;
      in_valid   = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_outstanding !== 6'd5 || bank_out_valid !== 16'h0010 || in_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre got rd=%0d bov=%h busy=%b exp 5/0010/1", rd_outstanding, bank_out_valid, in_busy);
      end
      @(posedge clk);
      #2;
      rst_n      = 1'b0;
      done_valid = 1'b1;
      done_type  = 1'b0;
      done_index = 5'd0;
      exp_q.delete();
      m_free = '1;
      #1;
      checks++;
      if ({bank_out_valid, out_type, out_addr, out_index, read_done, write_done, data_out,
           rd_outstanding, wr_outstanding, tag_err, in_busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset got bov=%h rd=%0d busy=%b data=%h", bank_out_valid, rd_outstanding, in_busy, data_out);
      end
      cycle();
      checks++;
      if (read_done !== 1'b0 || rd_outstanding !== 6'd0 || in_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_hold got rdone=%b rd=%0d busy=%b exp 0/0/0", read_done, rd_outstanding, in_busy);
      end
      done_valid = 1'b0;
      rst_n      = 1'b1;
      fifo_grant = '1;
      repeat (2) cycle();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_hold_stall();
      test_tag_exhaust();
      test_same_cycle();
      test_write_credits();
      test_tag_err();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got xfer=%0d rdone=%0d exp 0/0", exp_q.size(), done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bank_txn_dispatcher.md
BANK_TXN_DISPATCHER -- requirements
Module: bank_txn_dispatcher

Interface
REQ-001 Parameter DATA_W, default 16: width of read-return data.
REQ-002 Parameter NUM_BANKS, default 16: bank FIFO count; power of 2, 2..64; BANK_W = log2(NUM_BANKS).
REQ-003 Parameter ADDR_W, default 24: request address width; ADDR_W > BANK_W.
REQ-004 Parameter RD_ENTRIES, default 32: read tags; power of 2, 2..64; IDX_W = log2(RD_ENTRIES).
REQ-005 Parameter WR_MAX, default 32: maximum outstanding writes, 1..255.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  in  1  request valid from rnic.
REQ-009 in_type  in  1  0 = read, 1 = write.
REQ-010 in_addr  in  ADDR_W  request address; bank = in_addr[BANK_W-1:0].
REQ-011 in_busy  out  1  request not accepted this cycle.
REQ-012 out_type, out_addr  out  1, ADDR_W  held request to bank FIFOs.
REQ-013 out_index  out  IDX_W  tag of held request (0 for writes).
REQ-014 bank_out_valid  out  NUM_BANKS  one-hot valid to the addressed bank FIFO.
REQ-015 fifo_grant  in  NUM_BANKS  per-bank FIFO ready.
REQ-016 done_valid, done_type, done_index, done_data  in  1, 1, IDX_W, DATA_W  completion from scheduler.
REQ-017 read_done, write_done  out  1, 1  completion pulses to rnic.
REQ-018 data_out  out  DATA_W  read-return data.
REQ-019 rd_outstanding, wr_outstanding  out  IDX_W+1, 8  live counts.
REQ-020 tag_err  out  1  sticky: read completion for a free tag.

Function
REQ-021 The block SHALL have one hold register (hold_valid plus request fields) feeding out_type/out_addr/out_index.
REQ-022 bank_out_valid SHALL equal hold_valid shifted to bit hold bank; zero when hold empty.
REQ-023 Transfer SHALL occur when hold_valid and fifo_grant[hold bank] are both 1; hold empties next edge unless refilled.
REQ-024 in_busy SHALL be combinational: (hold_valid and not transfer) or rd_outstanding==RD_ENTRIES or wr_outstanding==WR_MAX.
REQ-025 Accept = in_valid and not in_busy; an accepted request SHALL appear in hold on the next cycle (latency 1); back-to-back accept while transferring SHALL be supported.
REQ-026 Read accept SHALL allocate the lowest-numbered free tag from a RD_ENTRIES-bit free bitmap and mark it used at the same edge.
REQ-027 Read completion (done_valid, done_type=0) SHALL free done_index; alloc and free of the same tag in one cycle SHALL leave it used.
REQ-028 Read completion on an already-free tag SHALL not change bitmap or counters and SHALL set tag_err until reset.
REQ-029 rd_outstanding SHALL +1 on read accept, -1 on valid read completion, unchanged when both occur; same rule for wr_outstanding with writes.
REQ-030 Write completion with wr_outstanding==0 SHALL be ignored (no underflow) and SHALL set tag_err.
REQ-031 read_done / write_done SHALL pulse exactly one cycle, one cycle after done_valid of the matching type, including error completions.
REQ-032 data_out SHALL register done_data on read completion and hold it otherwise.
REQ-033 Counters SHALL never exceed RD_ENTRIES / WR_MAX; no wrap-around.

Reset
REQ-034 rst_n low SHALL asynchronously clear hold_valid, bank_out_valid, free bitmap (all free), counters, read_done, write_done, data_out, out_* fields, tag_err.
REQ-035 in_busy SHALL be 0 during and after reset (counters zero, hold empty).
REQ-036 Reset mid-operation SHALL discard the held request and all tags without emitting done pulses.

Verification
REQ-037 Read addr 0x000005, grant all 1 -> bank_out_valid=0x0020 next cycle, out_index=0, rd_outstanding=1.
REQ-038 fifo_grant[3]=0, write to bank 3 then second request -> in_busy=1 while held; grant[3]=1 -> transfer and second request accepted same cycle.
REQ-039 32 reads without completion -> tags 0..31, rd_outstanding=32, in_busy=1; complete tag 7 -> next read gets tag 7.
REQ-040 Same-cycle read accept and read completion of tag 2 -> rd_outstanding unchanged; read_done pulses next cycle with data_out=done_data.
REQ-041 Read completion on free tag 9 -> read_done pulse, counters unchanged, tag_err=1 until rst_n low.
REQ-042 rst_n low with hold full and rd_outstanding=5 -> all outputs zero immediately, in_busy=0.
